store_queue: RTL
================

STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 Parameter SQ_SIZE, default 8, number of store entries (power of two).
REQ-002 Parameter SQ_IDX_BITS, default $clog2(SQ_SIZE)+1, pointer width; MSB is the wrap bit.
REQ-003 Parameter N, default 2, dispatch and commit width.
REQ-004 Parameters NUM_FU_STORE, default 2, and NUM_FU_LOAD, default 2, execute and forwarding port counts.
REQ-005 clock  in  1  clock; all state updates on posedge.
REQ-006 reset  in  1  reset, synchronous, active-low.
REQ-007 dis_valid  in  N  store dispatch requests; slot 0 is oldest.
REQ-008 dis_idx  out  N x SQ_IDX_BITS  pointer assigned to each dispatch slot.
REQ-009 sq_avail  out  $clog2(N+1)  free entries, capped at N.
REQ-010 sq_tail  out  SQ_IDX_BITS  current tail pointer, used as load tail_store.
REQ-011 exe_valid / exe_idx / exe_addr / exe_data / exe_func  in  NUM_FU_STORE x (1, SQ_IDX_BITS, ADDR, DATA, MEM_FUNC)  resolved store address and data.
REQ-012 commit_cnt  in  $clog2(N+1)  number of oldest uncommitted stores retired this cycle.
REQ-013 squash  in  1  discard all uncommitted stores.
REQ-014 sq_addr / store_range / load_byte_info  in  NUM_FU_LOAD x (ADDR, SQ_IDX_BITS, MEM_FUNC)  load forwarding queries.
REQ-015 value / fwd_valid / forwarded  out  NUM_FU_LOAD x (DATA, 1, 4)  forwarded lane-aligned data, full-coverage flag, per-lane coverage mask.
REQ-016 dc_valid / dc_addr / dc_data / dc_mask  out  1, ADDR (word-aligned), DATA (lane-aligned), 4  store write request to dcache.
REQ-017 dc_accept  in  1  dcache accepts the current write request.

Function
REQ-018 The block SHALL keep three pointers: head (oldest, next to drain), commit (first uncommitted), and tail (next free); occupancy SHALL be tail-head modulo 2*SQ_SIZE.
REQ-019 Full SHALL be occupancy==SQ_SIZE; empty SHALL be head==tail; sq_avail SHALL be computed from registered state only, with no credit for a same-cycle drain.
REQ-020 Dispatch: the k-th asserted dis_valid bit SHALL receive tail+k, the entry SHALL be cleared (addr_known=0), and tail SHALL advance by popcount(dis_valid); dis_valid popcount above sq_avail is illegal.
REQ-021 Execute: on exe_valid the entry at exe_idx SHALL store addr[31:2], byte mask, and data shifted to lanes: BYTE -> mask 1<<addr[1:0]; HALF -> 3<<addr[1:0]; WORD -> 4'b1111 with addr[1:0]==0; it SHALL then set addr_known=1 on the next cycle.
REQ-022 Commit: commit SHALL advance by commit_cnt; commit_cnt SHALL not exceed tail-commit.
REQ-023 Drain: dc_valid SHALL be 1 when head!=commit and entry[head].addr_known; dc_* SHALL be driven from registered state and held stable until dc_accept; dc_valid && dc_accept SHALL advance head next cycle; at most one drain per cycle.
REQ-024 Squash: tail SHALL become the post-commit value of commit (commit_cnt applied first); dis_valid SHALL be ignored in a squash cycle; committed entries and drain SHALL be unaffected.
REQ-025 Forwarding SHALL be combinational on registered entries: the candidate set SHALL be entries with pointers in [head, store_range), addr_known=1, and word address equal to sq_addr[31:2].
REQ-026 The load lane mask SHALL be derived from load_byte_info and sq_addr[1:0] as in REQ-021; for each lane, the youngest candidate whose mask covers that lane SHALL supply value[lane], and forwarded[lane] SHALL be 1.
REQ-027 Lanes outside the load mask and uncovered lanes SHALL drive forwarded=0 and value=0.
REQ-028 fwd_valid SHALL be 1 iff every lane in the load mask is forwarded.
REQ-029 Contract: the RS SHALL issue a load only after all older stores have addr_known=1 one or more cycles earlier, and only while head<=store_range; same-cycle execute data SHALL NOT be forwarded.
REQ-030 store_range==head SHALL yield no candidates; comparisons SHALL use the wrap bit so that a full-queue range forwards from all SQ_SIZE entries.

Reset
REQ-031 While reset==0 at posedge, head, commit, and tail SHALL be 0 and all entries cleared; outputs SHALL be sq_avail=N (or SQ_SIZE if smaller), sq_tail=0, dc_valid=0, fwd_valid=0, forwarded=0, and value=0.
REQ-032 A reset during a pending drain SHALL drop the request; dc_valid SHALL be 0 in the cycle after reset.

Verification
REQ-033 Dispatch 2 stores, then execute SB 0x1003 data 0xAB; query LB 0x1003 with range=2 -> value=0xAB000000, forwarded=4'b1000, fwd_valid=1.
REQ-034 Issue SW 0x2000 0x11223344 (older) and SH 0x2002 0xBEEF (younger); query LW 0x2000 -> value=0xBEEF3344, forwarded=4'b1111, fwd_valid=1.
REQ-035 Issue SB 0x3001 0x55 only; query LW 0x3000 -> forwarded=4'b0010, fwd_valid=0, value=0x00005500.
REQ-036 Fill 8 entries -> sq_avail=0; commit 2 while holding dc_accept=0 for 3 cycles -> dc_valid stable with unchanged head; release accept -> 2 drains on consecutive cycles, then sq_avail=2.
REQ-037 Run 6 dispatched, 2 committed, with squash plus commit_cnt=1 in the same cycle, and dis_valid=2'b11 -> tail=head+3, dis_valid ignored, 3 drains follow.
REQ-038 Wrap pointers past 2*SQ_SIZE -> forwarding across index 7->0 selects the correct youngest store.

Source files
------------

// File: rtl/store_queue.sv
// Store queue: in-order store buffer with dispatch/execute/commit/drain and
// lane-wise youngest-store forwarding to loads. func encoding: 0 byte, 1 half, 2/3 word.
module store_queue #(
    parameter int SQ_SIZE      = 8,
    parameter int SQ_IDX_BITS  = $clog2(SQ_SIZE) + 1,
    parameter int N            = 2,
    parameter int NUM_FU_STORE = 2,
    parameter int NUM_FU_LOAD  = 2
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [N-1:0]                        dis_valid,
    output logic [N*SQ_IDX_BITS-1:0]            dis_idx,
    output logic [$clog2(N+1)-1:0]              sq_avail,
    output logic [SQ_IDX_BITS-1:0]              sq_tail,
    input  logic [NUM_FU_STORE-1:0]             exe_valid,
    input  logic [NUM_FU_STORE*SQ_IDX_BITS-1:0] exe_idx,
    input  logic [NUM_FU_STORE*32-1:0]          exe_addr,
    input  logic [NUM_FU_STORE*32-1:0]          exe_data,
    input  logic [NUM_FU_STORE*2-1:0]           exe_func,
    input  logic [$clog2(N+1)-1:0]              commit_cnt,
    input  logic                                squash,
    input  logic [NUM_FU_LOAD*32-1:0]           sq_addr,
    input  logic [NUM_FU_LOAD*SQ_IDX_BITS-1:0]  store_range,
    input  logic [NUM_FU_LOAD*2-1:0]            load_byte_info,
    output logic [NUM_FU_LOAD*32-1:0]           value,
    output logic [NUM_FU_LOAD-1:0]              fwd_valid,
    output logic [NUM_FU_LOAD*4-1:0]            forwarded,
    output logic                                dc_valid,
    output logic [31:0]                         dc_addr,
    output logic [31:0]                         dc_data,
    output logic [3:0]                          dc_mask,
    input  logic                                dc_accept
);

    localparam int PB = SQ_IDX_BITS - 1;
    localparam int AW = $clog2(N + 1);

    logic [SQ_IDX_BITS-1:0] head, commit, tail;
    logic [29:0]            ent_addr  [SQ_SIZE];
    logic [31:0]            ent_data  [SQ_SIZE];
    logic [3:0]             ent_mask  [SQ_SIZE];
    logic                   ent_known [SQ_SIZE];

    logic [SQ_IDX_BITS-1:0] dis_ptr [N];
    logic [SQ_IDX_BITS-1:0] tail_dis;
    logic [SQ_IDX_BITS-1:0] commit_next;
    logic [SQ_IDX_BITS-1:0] free_cnt;
    logic [PB-1:0]          head_slot;
    logic [PB-1:0]          exe_slot [NUM_FU_STORE];
    logic [29:0]            exe_word [NUM_FU_STORE];
    logic [3:0]             exe_mask [NUM_FU_STORE];
    logic [31:0]            exe_lane [NUM_FU_STORE];
    logic                   unused_exe_wrap;

    function automatic logic [3:0] lane_mask(input logic [1:0] func, input logic [1:0] lo);
        case (func)
            2'd0:    lane_mask = 4'b0001 << lo;
            2'd1:    lane_mask = 4'b0011 << lo;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_expand(input logic [3:0] m);
        for (int b = 0; b < 4; b++) lane_expand[b*8 +: 8] = {8{m[b]}};
    endfunction

    assign head_slot   = head[PB-1:0];
    assign commit_next = commit + SQ_IDX_BITS'(commit_cnt);
    assign free_cnt    = SQ_IDX_BITS'(SQ_SIZE) - (tail - head);
    assign sq_avail    = (free_cnt > SQ_IDX_BITS'(N)) ? AW'(N) : AW'(free_cnt);
    assign sq_tail     = tail;

    // k-th asserted dispatch slot gets tail+k
    always_comb begin
        tail_dis = tail;
        dis_idx  = '0;
        for (int i = 0; i < N; i++) begin
            dis_ptr[i] = tail_dis;
            dis_idx[i*SQ_IDX_BITS +: SQ_IDX_BITS] = tail_dis;
            if (dis_valid[i]) tail_dis = tail_dis + SQ_IDX_BITS'(1);
        end
    end

    always_comb begin
        unused_exe_wrap = 1'b0;
        for (int f = 0; f < NUM_FU_STORE; f++) begin
            exe_slot[f]     = exe_idx[f*SQ_IDX_BITS +: PB];
            unused_exe_wrap = unused_exe_wrap ^ exe_idx[f*SQ_IDX_BITS + PB];
            exe_word[f]     = exe_addr[f*32+2 +: 30];
            exe_mask[f]     = lane_mask(exe_func[f*2 +: 2], exe_addr[f*32 +: 2]);
            exe_lane[f]     = (exe_data[f*32 +: 32] << {exe_addr[f*32 +: 2], 3'b000})
                              & lane_expand(exe_mask[f]);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head   <= '0;
            commit <= '0;
            tail   <= '0;
            for (int j = 0; j < SQ_SIZE; j++) begin
                ent_addr[j]  <= '0;
                ent_data[j]  <= '0;
                ent_mask[j]  <= '0;
                ent_known[j] <= 1'b0;
            end
        end else begin
            commit <= commit_next;
            tail   <= squash ? commit_next : tail_dis;
            if (dc_valid && dc_accept) head <= head + SQ_IDX_BITS'(1);
            if (!squash) begin
                for (int i = 0; i < N; i++) begin
                    if (dis_valid[i]) ent_known[dis_ptr[i][PB-1:0]] <= 1'b0;
                end
            end
            for (int f = 0; f < NUM_FU_STORE; f++) begin
                if (exe_valid[f]) begin
                    ent_addr[exe_slot[f]]  <= exe_word[f];
                    ent_data[exe_slot[f]]  <= exe_lane[f];
                    ent_mask[exe_slot[f]]  <= exe_mask[f];
                    ent_known[exe_slot[f]] <= 1'b1;
                end
            end
        end
    end

    assign dc_valid = (head != commit) && ent_known[head_slot];
    assign dc_addr  = {ent_addr[head_slot], 2'b00};
    assign dc_data  = ent_data[head_slot];
    assign dc_mask  = ent_mask[head_slot];

    // Walk oldest to youngest from head so later hits overwrite earlier ones per lane.
    always_comb begin
        logic [SQ_IDX_BITS-1:0] span;
        logic [PB-1:0]          slot;
        logic [3:0]             lmask;
        logic [3:0]             hit;
        logic [31:0]            data;
        value     = '0;
        fwd_valid = '0;
        forwarded = '0;
        span      = '0;
        slot      = '0;
        lmask     = '0;
        hit       = '0;
        data      = '0;
        for (int l = 0; l < NUM_FU_LOAD; l++) begin
            span  = store_range[l*SQ_IDX_BITS +: SQ_IDX_BITS] - head;
            lmask = lane_mask(load_byte_info[l*2 +: 2], sq_addr[l*32 +: 2]);
            hit   = '0;
            data  = '0;
            for (int k = 0; k < SQ_SIZE; k++) begin
                slot = head_slot + PB'(k);
                if ((SQ_IDX_BITS'(k) < span) && ent_known[slot] &&
                    (ent_addr[slot] == sq_addr[l*32+2 +: 30])) begin
                    for (int b = 0; b < 4; b++) begin
                        if (ent_mask[slot][b]) begin
                            data[b*8 +: 8] = ent_data[slot][b*8 +: 8];
                            hit[b]         = 1'b1;
                        end
                    end
                end
            end
            hit                  = hit & lmask;
            value[l*32 +: 32]    = data & lane_expand(hit);
            forwarded[l*4 +: 4]  = hit;
            fwd_valid[l]         = (hit == lmask);
        end
    end

endmodule
